aes_word_loader: RTL and testbench
==================================

# aes_word_loader

Upstream host-side loader for the AES_top encryption core. Accepts 32-bit register writes that assemble the 128-bit plaintext and key, launches one encryption on a start pulse by driving the core's enable, data and key inputs, captures the 128-bit result when the core flags it valid, and exposes it as four readable 32-bit words. A watchdog aborts the operation if the core never responds.

## Interface

- TIMEOUT_CYCLES, 255, maximum cycles in RUN before abort (1..255)
- CNT_W, 8, width of the RUN cycle counter (must hold TIMEOUT_CYCLES-1)

- AES_clk  in  1  clock, rising edge
- AES_rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  host write strobe
- wr_sel  in  3  0-3 = data word 0-3, 4-7 = key word 0-3; word 0 = bits [127:96], word 3 = bits [31:0]
- wr_data  in  32  write value
- start  in  1  launch request, single-cycle
- rd_sel  in  2  result word select, same word ordering as wr_sel
- rd_data  out  32  combinational mux of result register
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result captured
- timeout  out  1  one-cycle pulse, operation aborted
- wr_err  out  1  one-cycle pulse, write or start rejected while busy
- aes_en  out  1  to core AES_en
- aes_data_in  out  128  to core AES_data_in (the data staging register)
- aes_key_in  out  128  to core AES_key_in (the key staging register)
- aes_data_out  in  128  from core AES_data_out
- aes_data_out_valid  in  1  from core AES_data_out_valid

## Operation

- Reset: state IDLE; data, key, result registers = 0; counter = 0; aes_en, done, timeout, wr_err = 0; busy = 0. Reset mid-operation abandons it immediately, with no done/timeout.
- States: IDLE -> RUN -> GAP -> IDLE.
- IDLE: wr_en updates the selected 32-bit slice. start moves to RUN and sets aes_en = 1, counter = 0. A write and start in the same cycle: the write commits at the same edge, so the core sees the new value.
- RUN: aes_en held 1; data and key held stable (writes blocked). Counter increments each cycle.
  - aes_data_out_valid = 1: result <= aes_data_out, done pulse, aes_en <= 0, go to GAP.
  - Else counter == TIMEOUT_CYCLES-1: timeout pulse, aes_en <= 0, result unchanged, go to GAP.
  - Valid and timeout condition in the same cycle: valid wins (capture and done, no timeout).
- GAP: aes_en = 0 for exactly one cycle; guarantees an enable low gap between operations. Then go to IDLE.
- In RUN or GAP: wr_en or start is ignored (no register or state change) and pulses wr_err the next cycle. wr_en and start in the same cycle give a single wr_err pulse.
- aes_data_out_valid in IDLE or GAP is ignored.
- rd_data is readable at any time, including while busy, and shows the last captured result.

## Timing

- start sampled at edge k: busy = 1 and aes_en = 1 after edge k.
- valid sampled at edge m: done = 1, result updated, aes_en = 0 after edge m. busy falls after edge m+1. The earliest accepted next start is sampled at edge m+2.
- Timeout: valid never high. aes_en is high for exactly TIMEOUT_CYCLES cycles. The timeout pulse follows the edge where counter = TIMEOUT_CYCLES-1.
- done, timeout and wr_err are registered, one cycle wide, and mutually exclusive per operation (wr_err aside).

## Test plan

- Reset and load: write data 00000081_00000000_00000000_00000000 and key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc via wr_sel 0-7. Required: aes_data_in and aes_key_in equal those values exactly, aes_en = 0, busy = 0.
- Normal run: start, with a stub core asserting valid 11 cycles later with 3925841d_02dc09fb_dc118597_196a0b32. Required: aes_en high for 11 cycles, done for one cycle, rd_sel 0-3 read 3925841d, 02dc09fb, dc118597, 196a0b32, busy low 2 cycles after valid.
- Busy protection: while in RUN, write wr_sel 0 = a6f2daeb and pulse start. Required: aes_data_in unchanged, two wr_err pulses, one operation only.
- Timeout: TIMEOUT_CYCLES = 20, stub never asserts valid. Required: aes_en high exactly 20 cycles, timeout pulse, no done, result unchanged.
- Valid on the last counted cycle: valid arrives in the same cycle as the timeout condition. Required: done = 1, timeout = 0, result captured.
- Async reset mid-RUN: drop AES_rst_n between clock edges. Required: aes_en and busy clear immediately, result = 0, no done; after release, write+start in the same cycle launches with the new data.

Source files
------------

// File: rtl/aes_word_loader.sv
// Host-side loader for the AES core: assembles plaintext/key from 32-bit writes,
// runs one encryption per start, captures the result and aborts on a stalled core.
module aes_word_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic          AES_clk,
  input  logic          AES_rst_n,
  input  logic          wr_en,
  input  logic [2:0]    wr_sel,
  input  logic [31:0]   wr_data,
  input  logic          start,
  input  logic [1:0]    rd_sel,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          wr_err,
  output logic          aes_en,
  output logic [127:0]  aes_data_in,
  output logic [127:0]  aes_key_in,
  input  logic [127:0]  aes_data_out,
  input  logic          aes_data_out_valid
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   data_q, data_d;
  logic [BLK_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               wr_err_q, wr_err_d;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                 input logic [1:0]       idx,
                                                 input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      key_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      key_q     <= key_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    key_d     = key_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    wr_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A write coincident with start commits at the same edge as the launch.
        if (wr_en) begin
          if (wr_sel[2]) key_d  = put_word(key_q,  wr_sel[1:0], wr_data);
          else           data_d = put_word(data_q, wr_sel[1:0], wr_data);
        end
        if (start) begin
          state_d = S_RUN;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        wr_err_d = wr_en | start;
        // Valid takes priority over a watchdog expiry in the same cycle.
        if (aes_data_out_valid) begin
          result_d = aes_data_out;
          done_d   = 1'b1;
          en_d     = 1'b0;
          state_d  = S_GAP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          en_d      = 1'b0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        wr_err_d = wr_en | start;
        en_d     = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // Result readback, available at any time.
  always_comb begin
    rd_data = '0;
    case (rd_sel)
      2'd0:    rd_data = result_q[127:96];
      2'd1:    rd_data = result_q[95:64];
      2'd2:    rd_data = result_q[63:32];
      default: rd_data = result_q[31:0];
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign wr_err      = wr_err_q;
  assign aes_en      = en_q;
  assign aes_data_in = data_q;
  assign aes_key_in  = key_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader; the bench drives the core-side valid/result itself.
module tb_aes_word_loader;

  logic          AES_clk;
  logic          AES_rst_n;
  logic          wr_en;
  logic [2:0]    wr_sel;
  logic [31:0]   wr_data;
  logic          start;
  logic [1:0]    rd_sel;
  logic [31:0]   rd_data;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          wr_err;
  logic          aes_en;
  logic [127:0]  aes_data_in;
  logic [127:0]  aes_key_in;
  logic [127:0]  aes_data_out;
  logic          aes_data_out_valid;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0, done_cnt = 0, to_cnt = 0, err_cnt = 0;
  int en0, done0, to0, err0;

  localparam logic [127:0] DATA = 128'h00000081_00000000_00000000_00000000;
  localparam logic [127:0] KEY  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] R1   = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] R2   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] R3   = 128'hcafef00d_12345678_9abcdef0_0badc0de;
  localparam logic [127:0] JUNK = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;

  aes_word_loader #(.TIMEOUT_CYCLES(20), .CNT_W(8)) dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .wr_en              (wr_en),
    .wr_sel             (wr_sel),
    .wr_data            (wr_data),
    .start              (start),
    .rd_sel             (rd_sel),
    .rd_data            (rd_data),
    .busy               (busy),
    .done               (done),
    .timeout            (timeout),
    .wr_err             (wr_err),
    .aes_en             (aes_en),
    .aes_data_in        (aes_data_in),
    .aes_key_in         (aes_key_in),
    .aes_data_out       (aes_data_out),
    .aes_data_out_valid (aes_data_out_valid)
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  // Mid-cycle pulse/level counters.
  always @(negedge AES_clk) begin
    if (aes_en)  en_cnt++;
    if (done)    done_cnt++;
    if (timeout) to_cnt++;
    if (wr_err)  err_cnt++;
  end

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [2:0] sel, input logic [31:0] val);
    wr_en = 1'b1; wr_sel = sel; wr_data = val;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    rd_sel = sel;
    #1;
    chk32(tag, rd_data, exp);
  endtask

  task automatic snap();
    en0 = en_cnt; done0 = done_cnt; to0 = to_cnt; err0 = err_cnt;
  endtask

  initial begin
    AES_rst_n = 1'b1;
    wr_en = 1'b0; wr_sel = 3'd0; wr_data = '0; start = 1'b0; rd_sel = 2'd0;
    aes_data_out = '0; aes_data_out_valid = 1'b0;
    #1 AES_rst_n = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_en", aes_en, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_wr_err", wr_err, 1'b0);
    chk128("rst_data", aes_data_in, '0);
    chk128("rst_key", aes_key_in, '0);
    chk32("rst_rd", rd_data, 32'h0);
    tick(); tick();
    AES_rst_n = 1'b1;
    tick();

    // Load data and key.
    write_word(3'd0, 32'h00000081);
    write_word(3'd1, 32'h00000000);
    write_word(3'd2, 32'h00000000);
    write_word(3'd3, 32'h00000000);
    write_word(3'd4, 32'haa2bdb40);
    write_word(3'd5, 32'hbff6a5e8);
    write_word(3'd6, 32'hcaa9ba3e);
    write_word(3'd7, 32'hbc1e2acc);
    chk128("load_data", aes_data_in, DATA);
    chk128("load_key", aes_key_in, KEY);
    chk1("load_en", aes_en, 1'b0);
    chk1("load_busy", busy, 1'b0);

    // Normal run: valid sampled 11 edges after start.
    snap();
    start = 1'b1; tick(); start = 1'b0;
    chk1("run_busy", busy, 1'b1);
    chk1("run_en", aes_en, 1'b1);
    repeat (10) tick();
    chk1("run_no_done_yet", done, 1'b0);
    aes_data_out = R1; aes_data_out_valid = 1'b1;
    tick();
    aes_data_out_valid = 1'b0; aes_data_out = '0;
    chk1("run_done", done, 1'b1);
    chk1("run_en_low", aes_en, 1'b0);
    chk1("run_busy_gap", busy, 1'b1);
    tick();
    chk1("run_done_one", done, 1'b0);
    chk1("run_busy_low", busy, 1'b0);
    chkn("run_en_cycles", en_cnt - en0, 11);
    chkn("run_done_cnt", done_cnt - done0, 1);
    read_check("run_rd0", 2'd0, 32'h3925841d);
    read_check("run_rd1", 2'd1, 32'h02dc09fb);
    read_check("run_rd2", 2'd2, 32'hdc118597);
    read_check("run_rd3", 2'd3, 32'h196a0b32);

    // Busy protection: write and start while running are rejected.
    snap();
    start = 1'b1; tick(); start = 1'b0;
    write_word(3'd0, 32'ha6f2daeb);
    chk1("bp_err1", wr_err, 1'b1);
    tick();
    chk1("bp_err_gap", wr_err, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk1("bp_err2", wr_err, 1'b1);
    chk128("bp_data_held", aes_data_in, DATA);
    aes_data_out = R2; aes_data_out_valid = 1'b1;
    tick();
    aes_data_out_valid = 1'b0; aes_data_out = '0;
    chk1("bp_done", done, 1'b1);
    repeat (4) tick();
    chk1("bp_idle", busy, 1'b0);
    chk128("bp_data_final", aes_data_in, DATA);
    chkn("bp_err_cnt", err_cnt - err0, 2);
    chkn("bp_done_cnt", done_cnt - done0, 1);
    read_check("bp_rd0", 2'd0, 32'h00112233);

    // Watchdog: no valid, 20 enable cycles; combined write+start gives one wr_err.
    snap();
    start = 1'b1; tick(); start = 1'b0;
    wr_en = 1'b1; start = 1'b1; wr_sel = 3'd4; wr_data = 32'hffffffff;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk1("to_err", wr_err, 1'b1);
    repeat (18) tick();
    chk1("to_not_yet", timeout, 1'b0);
    chk1("to_en_last", aes_en, 1'b1);
    tick();
    chk1("to_pulse", timeout, 1'b1);
    chk1("to_no_done", done, 1'b0);
    chk1("to_en_low", aes_en, 1'b0);
    aes_data_out = JUNK; aes_data_out_valid = 1'b1;
    tick();
    aes_data_out_valid = 1'b0; aes_data_out = '0;
    chk1("to_pulse_one", timeout, 1'b0);
    chk1("to_gap_valid_ignored", done, 1'b0);
    chk1("to_idle", busy, 1'b0);
    tick();
    chkn("to_en_cycles", en_cnt - en0, 20);
    chkn("to_cnt", to_cnt - to0, 1);
    chkn("to_done_cnt", done_cnt - done0, 0);
    chkn("to_err_cnt", err_cnt - err0, 1);
    chk128("to_key_held", aes_key_in, KEY);
    read_check("to_rd0", 2'd0, 32'h00112233);
    read_check("to_rd3", 2'd3, 32'hccddeeff);

    // Valid coincides with the last counted cycle.
    snap();
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    aes_data_out = R3; aes_data_out_valid = 1'b1;
    tick();
    aes_data_out_valid = 1'b0; aes_data_out = '0;
    chk1("edge_done", done, 1'b1);
    chk1("edge_no_timeout", timeout, 1'b0);
    tick(); tick();
    chkn("edge_to_cnt", to_cnt - to0, 0);
    chkn("edge_en_cycles", en_cnt - en0, 20);
    read_check("edge_rd0", 2'd0, 32'hcafef00d);
    read_check("edge_rd3", 2'd3, 32'h0badc0de);

    // Asynchronous reset in the middle of a run.
    snap();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    #2 AES_rst_n = 1'b0;
    #1;
    chk1("ar_en", aes_en, 1'b0);
    chk1("ar_busy", busy, 1'b0);
    chk128("ar_data", aes_data_in, '0);
    read_check("ar_rd0", 2'd0, 32'h0);
    tick();
    AES_rst_n = 1'b1;
    tick();
    chkn("ar_no_done", done_cnt - done0, 0);
    chkn("ar_no_timeout", to_cnt - to0, 0);
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 32'hdeadbeef; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk1("ar_relaunch_busy", busy, 1'b1);
    chk1("ar_relaunch_en", aes_en, 1'b1);
    chk128("ar_relaunch_data", aes_data_in, 128'h00000000_00000000_00000000_deadbeef);
    aes_data_out = R1; aes_data_out_valid = 1'b1;
    tick();
    aes_data_out_valid = 1'b0;
    chk1("ar_relaunch_done", done, 1'b1);
    read_check("ar_relaunch_rd1", 2'd1, 32'h02dc09fb);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
